// File: rtl/iter_accum_pkg.sv
// Shared constants for the iterative accumulation controller: FSM state codes,
// ALU opcodes (common with the ALU) and mode encodings.
package iter_accum_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_OP   = 3'd3;
    localparam logic [2:0] ST_DEC  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_ONE   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_SUB1  = 4'd4;
    localparam logic [3:0] OP_PASSA = 4'd5;

    localparam logic MODE_FACT = 1'b0;
    localparam logic MODE_SUM  = 1'b1;

    // Accumulator seed opcode: 1 for a product, 0 for a sum.
    function automatic logic [3:0] seed_op(input logic mode);
        return (mode == MODE_SUM) ? OP_ZERO : OP_ONE;
    endfunction

    function automatic logic [3:0] accum_op(input logic mode);
        return (mode == MODE_SUM) ? OP_ADD : OP_MUL;
    endfunction

endpackage

// File: rtl/iter_accum_ctrl.sv
// FSM controller sequencing the register file + ALU through N! or 1+..+N,
// with an iteration limit, abort and Busy/Done/Err status.
module iter_accum_ctrl
    import iter_accum_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int SW       = 4,
    parameter int ZERO_REG = 0,
    parameter int N_REG    = 1,
    parameter int ACC_REG  = 3,
    parameter int MAX_ITER = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Start,
    input  logic          Mode,
    input  logic          Abort,
    input  logic [DW-1:0] Datapath,
    output logic          IE,
    output logic          WE,
    output logic [AW-1:0] WA,
    output logic          REA,
    output logic          REB,
    output logic [AW-1:0] RAA,
    output logic [AW-1:0] RAB,
    output logic [SW-1:0] S_ALU,
    output logic          Cin,
    output logic          OE,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    localparam int              CW         = $clog2(MAX_ITER + 1);
    localparam logic [CW-1:0]   ITER_LIMIT = CW'(MAX_ITER);
    localparam logic [DW-1:0]   DP_ZERO    = {DW{1'b0}};
    localparam logic [DW-1:0]   DP_ONE     = DW'(1);
    localparam logic [AW-1:0]   A_ZERO     = AW'(ZERO_REG);
    localparam logic [AW-1:0]   A_N        = AW'(N_REG);
    localparam logic [AW-1:0]   A_ACC      = AW'(ACC_REG);

    logic [2:0]    state_r;
    logic [2:0]    next_state_s;
    logic          mode_r;
    logic          mode_nxt_s;
    logic          err_r;
    logic          err_nxt_s;
    logic [CW-1:0] iter_cnt_r;
    logic [CW-1:0] iter_cnt_nxt_s;
    logic          launch_s;
    logic          stop_s;
    logic          limit_s;

    logic          ie_s, we_s, rea_s, reb_s, cin_s, oe_s, busy_s, done_s, err_s;
    logic [AW-1:0] wa_s, raa_s, rab_s;
    logic [SW-1:0] s_alu_s;

    // Loop-exit conditions evaluated on the decremented N (unsigned compare).
    always_comb begin
        launch_s = Start && !Abort;
        stop_s   = (mode_r == MODE_SUM) ? (Datapath == DP_ZERO) : (Datapath <= DP_ONE);
        limit_s  = (iter_cnt_r == ITER_LIMIT);
    end

    // Next-state logic, with mode and error flags that travel alongside the state.
    always_comb begin
        next_state_s = ST_IDLE;
        mode_nxt_s   = mode_r;
        err_nxt_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    next_state_s = ST_INIT;
                    mode_nxt_s   = Mode;
                    err_nxt_s    = 1'b0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INIT: next_state_s = Abort ? ST_IDLE : ST_LOAD;
            ST_LOAD: begin
                if (Abort) begin
                    next_state_s = ST_IDLE;
                end else if (Datapath == DP_ZERO) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_OP;
                end
            end
            ST_OP:   next_state_s = Abort ? ST_IDLE : ST_DEC;
            ST_DEC: begin
                if (Abort) begin
                    next_state_s = ST_IDLE;
                end else if (stop_s) begin
                    next_state_s = ST_DONE;
                end else if (limit_s) begin
                    next_state_s = ST_DONE;
                    err_nxt_s    = 1'b1;
                end else begin
                    next_state_s = ST_OP;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Iteration counter: cleared on launch, bumped once per accumulate step.
    always_comb begin
        iter_cnt_nxt_s = iter_cnt_r;
        if ((state_r == ST_IDLE) && launch_s) begin
            iter_cnt_nxt_s = {CW{1'b0}};
        end else if ((state_r == ST_OP) && !Abort) begin
            iter_cnt_nxt_s = iter_cnt_r + CW'(1);
        end else begin
            iter_cnt_nxt_s = iter_cnt_r;
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        ie_s    = 1'b0;
        we_s    = 1'b0;
        wa_s    = {AW{1'b0}};
        rea_s   = 1'b0;
        reb_s   = 1'b0;
        raa_s   = {AW{1'b0}};
        rab_s   = {AW{1'b0}};
        s_alu_s = {SW{1'b0}};
        cin_s   = 1'b0;
        oe_s    = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (next_state_s)
            ST_IDLE: busy_s = 1'b0;
            ST_INIT: begin
                busy_s  = 1'b1;
                we_s    = 1'b1;
                wa_s    = A_ACC;
                rea_s   = 1'b1;
                raa_s   = A_ZERO;
                s_alu_s = SW'(seed_op(mode_nxt_s));
            end
            ST_LOAD: begin
                busy_s = 1'b1;
                ie_s   = 1'b1;
                we_s   = 1'b1;
                wa_s   = A_N;
            end
            ST_OP: begin
                busy_s  = 1'b1;
                we_s    = 1'b1;
                wa_s    = A_ACC;
                rea_s   = 1'b1;
                reb_s   = 1'b1;
                raa_s   = A_N;
                rab_s   = A_ACC;
                s_alu_s = SW'(accum_op(mode_nxt_s));
            end
            ST_DEC: begin
                busy_s  = 1'b1;
                we_s    = 1'b1;
                wa_s    = A_N;
                rea_s   = 1'b1;
                raa_s   = A_N;
                s_alu_s = SW'(OP_SUB1);
                cin_s   = 1'b1;
            end
            ST_DONE: begin
                busy_s  = 1'b1;
                rea_s   = 1'b1;
                raa_s   = A_ACC;
                s_alu_s = SW'(OP_PASSA);
                oe_s    = 1'b1;
                done_s  = 1'b1;
                err_s   = err_nxt_s;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_FACT;
            err_r      <= 1'b0;
            iter_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= next_state_s;
            mode_r     <= mode_nxt_s;
            err_r      <= err_nxt_s;
            iter_cnt_r <= iter_cnt_nxt_s;
        end
    end

    // Output registers; reset clears them without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IE    <= 1'b0;
            WE    <= 1'b0;
            WA    <= {AW{1'b0}};
            REA   <= 1'b0;
            REB   <= 1'b0;
            RAA   <= {AW{1'b0}};
            RAB   <= {AW{1'b0}};
            S_ALU <= {SW{1'b0}};
            Cin   <= 1'b0;
            OE    <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            IE    <= ie_s;
            WE    <= we_s;
            WA    <= wa_s;
            REA   <= rea_s;
            REB   <= reb_s;
            RAA   <= raa_s;
            RAB   <= rab_s;
            S_ALU <= s_alu_s;
            Cin   <= cin_s;
            OE    <= oe_s;
            Busy  <= busy_s;
            Done  <= done_s;
            Err   <= err_s;
        end
    end

endmodule
